// File: rtl/systolic_feeder_if.sv
// Operand-feeder bus: tile-row load port, stream control and the skewed
// data/weight lanes toward the systolic array.
// master = loader/controller side, slave = systolic_feeder.
interface systolic_feeder_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned EW    = 32;
  localparam int unsigned ROW_W = $clog2(N);

  logic                 wr_en;
  logic                 wr_sel;
  logic [ROW_W-1:0]     wr_row;
  logic [N*EW-1:0]      wr_data;
  logic                 wr_drop;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [N*EW-1:0]      left_d_bus;
  logic [N-1:0]         left_d_v;
  logic [N*EW-1:0]      top_w_bus;
  logic [N-1:0]         top_w_v;

  modport master (
    output wr_en, wr_sel, wr_row, wr_data, start,
    input  wr_drop, busy, done, left_d_bus, left_d_v, top_w_bus, top_w_v
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_data, start,
    output wr_drop, busy, done, left_d_bus, left_d_v, top_w_bus, top_w_v
  );
endinterface

// File: rtl/systolic_feeder.sv
// Systolic-array operand feeder: buffers one NxN data tile (A) and one NxN
// weight tile (W), then streams them diagonally skewed onto the left/top
// lanes, followed by FLUSH_CYC all-valid zero beats and a one-cycle done.
// Optional double buffering: define SYSTOLIC_FEEDER_DBUF_EN.
module systolic_feeder #(
  parameter int unsigned N         = 8,
  parameter int unsigned FLUSH_CYC = N + 1
) (
  input  logic               clk,
  input  logic               rstn,
  systolic_feeder_if.slave   bus
);

  localparam int unsigned EW        = 32;
  localparam int unsigned BUS_W     = N * EW;
  localparam int unsigned ROW_W     = $clog2(N);
  localparam int unsigned STR_BEATS = 2 * N - 1;
  localparam int unsigned CNT_MAX   = (STR_BEATS > FLUSH_CYC) ? STR_BEATS : FLUSH_CYC;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  localparam int unsigned BANKS = 2;
`else
  localparam int unsigned BANKS = 1;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [BUS_W-1:0] a_mem [BANKS][N];
  logic [BUS_W-1:0] w_mem [BANKS][N];

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             start_ok;
  logic             wr_ok;
  logic             wr_bank;
  logic             rd_bank;
  logic             fwd_a, fwd_w;
  logic             drop_nxt;
  logic [BUS_W-1:0] ld_nxt, tw_nxt;
  logic [N-1:0]     lv_nxt, tv_nxt;

  assign start_ok = (state == ST_IDLE) && bus.start;

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  logic load_bank, strm_bank;

  // Bank roles: loads always land in load_bank; an accepted start hands it to the stream side
  always_ff @(posedge clk) begin
    if (!rstn) begin
      load_bank <= 1'b0;
      strm_bank <= 1'b0;
    end else if (start_ok) begin
      strm_bank <= load_bank;
      load_bank <= ~load_bank;
    end
  end

  // Loads never collide with the streaming bank, so none are dropped
  always_comb begin
    wr_ok    = 1'b1;
    wr_bank  = load_bank;
    rd_bank  = start_ok ? load_bank : strm_bank;
    drop_nxt = 1'b0;
  end
`else
  logic is_busy;

  // Single bank: writes are refused while the bank is being streamed
  always_comb begin
    is_busy  = (state == ST_STREAM) || (state == ST_FLUSH);
    wr_ok    = !is_busy;
    wr_bank  = 1'b0;
    rd_bank  = 1'b0;
    drop_nxt = bus.wr_en && is_busy;
  end
`endif

  // A write landing on the edge that launches beat 0 must be visible in that beat
  always_comb begin
    fwd_a = bus.wr_en && wr_ok && !bus.wr_sel && (wr_bank == rd_bank);
    fwd_w = bus.wr_en && wr_ok &&  bus.wr_sel && (wr_bank == rd_bank);
  end

  // Tile buffers (not reset; contents survive reset)
  always_ff @(posedge clk) begin
    if (bus.wr_en && wr_ok) begin
      if (bus.wr_sel) w_mem[wr_bank][bus.wr_row] <= bus.wr_data;
      else            a_mem[wr_bank][bus.wr_row] <= bus.wr_data;
    end
  end

  // State and beat counter register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: IDLE -> STREAM (2N-1 beats) -> FLUSH (FLUSH_CYC beats) -> DONE -> IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = ST_STREAM;
          cnt_nxt   = '0;
        end
      end
      ST_STREAM: begin
        if (cnt == CNT_W'(STR_BEATS - 1)) begin
          state_nxt = ST_FLUSH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt == CNT_W'(FLUSH_CYC - 1)) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Lane contents of the beat about to be registered; lane i carries element k = t - i
  always_comb begin
    int kk;
    kk     = 0;
    ld_nxt = '0;
    lv_nxt = '0;
    tw_nxt = '0;
    tv_nxt = '0;
    if (state_nxt == ST_STREAM) begin
      for (int i = 0; i < N; i++) begin
        kk = int'(cnt_nxt) - i;
        if (kk >= 0 && kk < int'(N)) begin
          lv_nxt[i +: 1] = 1'b1;
          tv_nxt[i +: 1] = 1'b1;
          if (fwd_a && bus.wr_row == ROW_W'(i))
            ld_nxt[i*EW +: EW] = bus.wr_data[kk*EW +: EW];
          else
            ld_nxt[i*EW +: EW] = a_mem[rd_bank][ROW_W'(i)][kk*EW +: EW];
          if (fwd_w && bus.wr_row == ROW_W'(kk))
            tw_nxt[i*EW +: EW] = bus.wr_data[i*EW +: EW];
          else
            tw_nxt[i*EW +: EW] = w_mem[rd_bank][ROW_W'(kk)][i*EW +: EW];
        end
      end
    end else if (state_nxt == ST_FLUSH) begin
      lv_nxt = '1;
      tv_nxt = '1;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.wr_drop    <= 1'b0;
      bus.left_d_bus <= '0;
      bus.left_d_v   <= '0;
      bus.top_w_bus  <= '0;
      bus.top_w_v    <= '0;
    end else begin
      bus.busy       <= (state_nxt == ST_STREAM) || (state_nxt == ST_FLUSH);
      bus.done       <= (state_nxt == ST_DONE);
      bus.wr_drop    <= drop_nxt;
      bus.left_d_bus <= ld_nxt;
      bus.left_d_v   <= lv_nxt;
      bus.top_w_bus  <= tw_nxt;
      bus.top_w_v    <= tv_nxt;
    end
  end

endmodule
